// File: rtl/sat_bin_pkg.sv
// -----------------------------------------------------------------------------
// sat_bin_pkg
//   Shared definitions for the bin load/store engines (store_bin, load_bin).
//   Holds the default widths of the var/lvl state RAM interfaces, the
//   store/load FSM state encoding and a helper that maps a bin number to the
//   first address of its slice in the var-id RAM.
// -----------------------------------------------------------------------------
package sat_bin_pkg;

    // Default geometry of one bin and of the backing RAMs.
    localparam int SB_NUM_VARS_A_BIN         = 8;
    localparam int SB_NUM_LVLS_A_BIN         = 8;
    localparam int SB_WIDTH_VARS             = 12;
    localparam int SB_WIDTH_LVL              = 16;
    localparam int SB_WIDTH_BIN_ID           = 10;
    localparam int SB_WIDTH_VAR_STATES       = 30;
    localparam int SB_WIDTH_LVL_STATES       = 30;
    localparam int SB_ADDR_WIDTH_VARS        = 9;
    localparam int SB_ADDR_WIDTH_VARS_STATES = 9;
    localparam int SB_ADDR_WIDTH_LVLS_STATES = 9;

    // Store/load FSM encoding, kept as plain constants so older tools that
    // compare against raw state values keep working.
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_STORE_VS = 2'd1;
    localparam logic [1:0] ST_STORE_LS = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    // First var-id RAM address of a bin: bin * slots_per_bin, computed at
    // 32 bits and truncated to the RAM address width.
    function automatic logic [SB_ADDR_WIDTH_VARS-1:0] bin_var_base(
        input logic [SB_WIDTH_BIN_ID-1:0] bin,
        input int unsigned                slots
    );
        logic [31:0] prod;
        prod = 32'(bin) * slots;
        return prod[SB_ADDR_WIDTH_VARS-1:0];
    endfunction

endpackage

// File: rtl/store_bin.sv
// -----------------------------------------------------------------------------
// store_bin
//   Writes one bin of engine state back to the var-state and lvl-state RAMs.
//   On start_store the bin number, level window and all var/lvl state slots
//   are snapshotted. The var phase walks the var-id RAM slice of the bin; each
//   returned var id (one cycle later) is the var-state address for the
//   matching snapshot slot, id 0 meaning an empty slot. The lvl phase writes
//   lvl slots to base_lvl+j for every level inside [base_lvl, cur_lvl].
//
// Ports
//   clk, rst               clock, asynchronous active-low reset
//   start_store            one-cycle request, honoured only when idle
//   request_bin_num_i      bin being written back
//   base_lvl_i, cur_lvl_i  level window held by the engine for this bin
//   var_states_i           NUM_VARS_A_BIN packed var-state slots
//   lvl_states_i           NUM_LVLS_A_BIN packed lvl-state slots
//   apply_store_o          high while busy (RAM port mux select)
//   done_store             one-cycle completion pulse
//   ram_addr_v_o / ram_data_v_i              var-id RAM read port (1-cycle)
//   ram_we/addr/data_v_state_o               var-state RAM write port
//   ram_we/addr/data_l_state_o               lvl-state RAM write port
// -----------------------------------------------------------------------------
module store_bin
    import sat_bin_pkg::*;
#(
    parameter int NUM_VARS_A_BIN         = SB_NUM_VARS_A_BIN,
    parameter int NUM_LVLS_A_BIN         = SB_NUM_LVLS_A_BIN,
    parameter int WIDTH_VARS             = SB_WIDTH_VARS,
    parameter int WIDTH_LVL              = SB_WIDTH_LVL,
    parameter int WIDTH_BIN_ID           = SB_WIDTH_BIN_ID,
    parameter int WIDTH_VAR_STATES       = SB_WIDTH_VAR_STATES,
    parameter int WIDTH_LVL_STATES       = SB_WIDTH_LVL_STATES,
    parameter int ADDR_WIDTH_VARS        = SB_ADDR_WIDTH_VARS,
    parameter int ADDR_WIDTH_VARS_STATES = SB_ADDR_WIDTH_VARS_STATES,
    parameter int ADDR_WIDTH_LVLS_STATES = SB_ADDR_WIDTH_LVLS_STATES
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start_store,
    input  logic [WIDTH_BIN_ID-1:0]                      request_bin_num_i,
    input  logic [WIDTH_LVL-1:0]                         base_lvl_i,
    input  logic [WIDTH_LVL-1:0]                         cur_lvl_i,
    input  logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0]   var_states_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0]   lvl_states_i,
    output logic                                         apply_store_o,
    output logic                                         done_store,
    input  logic [WIDTH_VARS-1:0]                        ram_data_v_i,
    output logic [ADDR_WIDTH_VARS-1:0]                   ram_addr_v_o,
    output logic                                         ram_we_v_state_o,
    output logic [ADDR_WIDTH_VARS_STATES-1:0]            ram_addr_v_state_o,
    output logic [WIDTH_VAR_STATES-1:0]                  ram_data_v_state_o,
    output logic                                         ram_we_l_state_o,
    output logic [ADDR_WIDTH_LVLS_STATES-1:0]            ram_addr_l_state_o,
    output logic [WIDTH_LVL_STATES-1:0]                  ram_data_l_state_o
);

    // vs_cnt must reach NUM_VARS_A_BIN (one extra cycle drains the RAM read).
    localparam int VS_CW = $clog2(NUM_VARS_A_BIN + 1);
    localparam int LS_CW = $clog2(NUM_LVLS_A_BIN + 1);

    localparam int VAR_BITS = WIDTH_VAR_STATES * NUM_VARS_A_BIN;
    localparam int LVL_BITS = WIDTH_LVL_STATES * NUM_LVLS_A_BIN;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]              state_q,    state_d;
    logic [VS_CW-1:0]        vs_cnt_q,   vs_cnt_d;
    logic [LS_CW-1:0]        ls_cnt_q,   ls_cnt_d;
    logic [WIDTH_BIN_ID-1:0] bin_q,      bin_d;
    logic [WIDTH_LVL-1:0]    base_lvl_q, base_lvl_d;
    logic [WIDTH_LVL-1:0]    cur_lvl_q,  cur_lvl_d;
    logic [VAR_BITS-1:0]     var_q,      var_d;
    logic [LVL_BITS-1:0]     lvl_q,      lvl_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            vs_cnt_q   <= '0;
            ls_cnt_q   <= '0;
            bin_q      <= '0;
            base_lvl_q <= '0;
            cur_lvl_q  <= '0;
            var_q      <= '0;
            lvl_q      <= '0;
        end else begin
            state_q    <= state_d;
            vs_cnt_q   <= vs_cnt_d;
            ls_cnt_q   <= ls_cnt_d;
            bin_q      <= bin_d;
            base_lvl_q <= base_lvl_d;
            cur_lvl_q  <= cur_lvl_d;
            var_q      <= var_d;
            lvl_q      <= lvl_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state. The snapshot is loaded only from IDLE, so a start_store
    // arriving mid-store cannot disturb the bin being written.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        vs_cnt_d   = vs_cnt_q;
        ls_cnt_d   = ls_cnt_q;
        bin_d      = bin_q;
        base_lvl_d = base_lvl_q;
        cur_lvl_d  = cur_lvl_q;
        var_d      = var_q;
        lvl_d      = lvl_q;

        case (state_q)
            ST_IDLE: begin
                if (start_store) begin
                    state_d    = ST_STORE_VS;
                    vs_cnt_d   = '0;
                    ls_cnt_d   = '0;
                    bin_d      = request_bin_num_i;
                    base_lvl_d = base_lvl_i;
                    cur_lvl_d  = cur_lvl_i;
                    var_d      = var_states_i;
                    lvl_d      = lvl_states_i;
                end
            end
            ST_STORE_VS: begin
                if (vs_cnt_q == VS_CW'(NUM_VARS_A_BIN)) begin
                    state_d  = ST_STORE_LS;
                    vs_cnt_d = '0;
                    ls_cnt_d = '0;
                end else begin
                    vs_cnt_d = vs_cnt_q + 1'b1;
                end
            end
            ST_STORE_LS: begin
                if (ls_cnt_q == LS_CW'(NUM_LVLS_A_BIN - 1)) begin
                    state_d  = ST_DONE;
                    ls_cnt_d = '0;
                end else begin
                    ls_cnt_d = ls_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Var phase datapath.
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH_VARS-1:0] var_base;
    logic [VS_CW-1:0]           vs_slot;
    logic                       in_vs;

    assign in_vs    = (state_q == ST_STORE_VS);
    assign var_base = bin_var_base(bin_q, NUM_VARS_A_BIN);
    // RAM data seen in count k+1 belongs to the address issued at count k.
    assign vs_slot  = vs_cnt_q - 1'b1;

    always_comb begin
        ram_addr_v_o       = '0;
        ram_we_v_state_o   = 1'b0;
        ram_addr_v_state_o = '0;
        ram_data_v_state_o = '0;

        if (in_vs && (vs_cnt_q < VS_CW'(NUM_VARS_A_BIN))) begin
            ram_addr_v_o = var_base + ADDR_WIDTH_VARS'(vs_cnt_q);
        end

        // A zero var id marks an unused slot: nothing to write back.
        if (in_vs && (vs_cnt_q != '0) && (ram_data_v_i != '0)) begin
            ram_we_v_state_o   = 1'b1;
            ram_addr_v_state_o = ADDR_WIDTH_VARS_STATES'(ram_data_v_i);
            ram_data_v_state_o = var_q[int'(vs_slot)*WIDTH_VAR_STATES +: WIDTH_VAR_STATES];
        end
    end

    // ------------------------------------------------------------------
    // Lvl phase datapath. The level sum carries one extra bit so a window
    // near the top of the level range can never wrap to low addresses.
    // ------------------------------------------------------------------
    logic [WIDTH_LVL:0] lvl_sum;
    logic               lvl_in_range;

    assign lvl_sum      = {1'b0, base_lvl_q} + (WIDTH_LVL+1)'(ls_cnt_q);
    assign lvl_in_range = (lvl_sum <= {1'b0, cur_lvl_q});

    always_comb begin
        ram_we_l_state_o   = 1'b0;
        ram_addr_l_state_o = '0;
        ram_data_l_state_o = '0;

        if ((state_q == ST_STORE_LS) && lvl_in_range) begin
            ram_we_l_state_o   = 1'b1;
            ram_addr_l_state_o = ADDR_WIDTH_LVLS_STATES'(lvl_sum[WIDTH_LVL-1:0]);
            ram_data_l_state_o = lvl_q[int'(ls_cnt_q)*WIDTH_LVL_STATES +: WIDTH_LVL_STATES];
        end
    end

    // ------------------------------------------------------------------
    // Status.
    // ------------------------------------------------------------------
    assign apply_store_o = (state_q != ST_IDLE);
    assign done_store    = (state_q == ST_DONE);

endmodule

// File: tb/tb_store_bin.sv
// -----------------------------------------------------------------------------
// tb_store_bin
//   Directed bench for store_bin. A timeline model (cycle index since the
//   start edge plus a snapshot of the request) predicts every output each
//   cycle; a var-id RAM model feeds ram_data_v_i. Per-test write counts and
//   cycle numbers are also pinned against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_store_bin;

    localparam int NV     = 8;
    localparam int NL     = 8;
    localparam int WS     = 30;
    localparam int C_DONE = NV + NL + 2;   // cycle 18 with defaults

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start_store = 1'b0;
    logic [9:0]       bin_i = '0;
    logic [15:0]      base_i = '0;
    logic [15:0]      cur_i = '0;
    logic [NV*WS-1:0] var_i = '0;
    logic [NL*WS-1:0] lvl_i = '0;
    logic             apply_store_o, done_store;
    logic [11:0]      ram_data_v_i = '0;
    logic [8:0]       ram_addr_v_o;
    logic             ram_we_v_state_o, ram_we_l_state_o;
    logic [8:0]       ram_addr_v_state_o, ram_addr_l_state_o;
    logic [29:0]      ram_data_v_state_o, ram_data_l_state_o;

    store_bin dut (
        .clk                (clk),
        .rst                (rst),
        .start_store        (start_store),
        .request_bin_num_i  (bin_i),
        .base_lvl_i         (base_i),
        .cur_lvl_i          (cur_i),
        .var_states_i       (var_i),
        .lvl_states_i       (lvl_i),
        .apply_store_o      (apply_store_o),
        .done_store         (done_store),
        .ram_data_v_i       (ram_data_v_i),
        .ram_addr_v_o       (ram_addr_v_o),
        .ram_we_v_state_o   (ram_we_v_state_o),
        .ram_addr_v_state_o (ram_addr_v_state_o),
        .ram_data_v_state_o (ram_data_v_state_o),
        .ram_we_l_state_o   (ram_we_l_state_o),
        .ram_addr_l_state_o (ram_addr_l_state_o),
        .ram_data_l_state_o (ram_data_l_state_o)
    );

    always #5 clk = ~clk;

    // var-id RAM, one cycle read latency
    logic [11:0] mem [512];
    always @(posedge clk) ram_data_v_i <= mem[ram_addr_v_o];

    int total = 0;
    int bad   = 0;
    int cnum  = 0;
    always @(posedge clk) cnum <= cnum + 1;

    // ---------------- timeline model ----------------
    int          cyc = 0;   // 0 idle, else cycle index after the start edge
    logic [9:0]  s_bin;
    logic [15:0] s_base, s_cur;
    logic [NV*WS-1:0] s_var;
    logic [NL*WS-1:0] s_lvl;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc <= 0;
        end else if (cyc == 0) begin
            if (start_store) begin
                cyc    <= 1;
                s_bin  <= bin_i;
                s_base <= base_i;
                s_cur  <= cur_i;
                s_var  <= var_i;
                s_lvl  <= lvl_i;
            end
        end else begin
            cyc <= (cyc == C_DONE) ? 0 : cyc + 1;
        end
    end

    // ---------------- per-cycle compare + monitor ----------------
    int nv = 0, nl = 0, nd = 0;
    int last_v_c = 0, last_l_c = 0, done_c = 0;
    logic [90:0] exp_v, act_v;
    int vb, id, sum, k, j;
    logic e_apply, e_done, e_wv, e_wl;
    logic [8:0] e_av, e_avs, e_als;
    logic [29:0] e_dvs, e_dls;

    always @(negedge clk) begin
        vb = (int'(s_bin) * NV) % 512;
        e_apply = (cyc != 0);
        e_done  = (cyc == C_DONE);
        e_av = '0; e_wv = 0; e_avs = '0; e_dvs = '0;
        e_wl = 0; e_als = '0; e_dls = '0;
        if (cyc >= 1 && cyc <= NV) e_av = 9'((vb + cyc - 1) % 512);
        if (cyc >= 2 && cyc <= NV + 1) begin
            k  = cyc - 2;
            id = int'(mem[(vb + k) % 512]);
            if (id != 0) begin
                e_wv  = 1;
                e_avs = 9'(id % 512);
                e_dvs = s_var[k*WS +: WS];
            end
        end
        if (cyc >= NV + 2 && cyc <= NV + NL + 1) begin
            j   = cyc - NV - 2;
            sum = int'(s_base) + j;
            if (sum <= int'(s_cur)) begin
                e_wl  = 1;
                e_als = 9'(sum % 512);
                e_dls = s_lvl[j*WS +: WS];
            end
        end
        exp_v = {e_apply, e_done, e_av, e_wv, e_avs, e_dvs, e_wl, e_als, e_dls};
        act_v = {apply_store_o, done_store, ram_addr_v_o, ram_we_v_state_o,
                 ram_addr_v_state_o, ram_data_v_state_o, ram_we_l_state_o,
                 ram_addr_l_state_o, ram_data_l_state_o};
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL outputs t=%0t cyc=%0d: got %h want %h", $time, cyc, act_v, exp_v);
        end
        if (ram_we_v_state_o) begin nv++; last_v_c = cnum; end
        if (ram_we_l_state_o) begin nl++; last_l_c = cnum; end
        if (done_store)       begin nd++; done_c = cnum; end
    end

    // ---------------- stimulus helpers ----------------
    int t0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic scramble();
        for (int s = 0; s < NV; s++) var_i[s*WS +: WS] = 30'($urandom);
        for (int s = 0; s < NL; s++) lvl_i[s*WS +: WS] = 30'($urandom);
    endtask

    // Drives one start pulse; t0 becomes the cnum value seen in cycle 1.
    task automatic do_start(input logic [9:0] b, input logic [15:0] bl,
                            input logic [15:0] cl, input bit rel_rst);
        @(posedge clk); #1;
        bin_i = b; base_i = bl; cur_i = cl;
        scramble();
        start_store = 1'b1;
        if (rel_rst) rst = 1'b1;
        @(posedge clk); #1;
        start_store = 1'b0;
        t0 = cnum;
        // new garbage on the inputs must not leak into the snapshot
        scramble();
        bin_i = ~b; base_i = ~bl; cur_i = ~cl;
    endtask

    function automatic int cyc_of(input int c);
        return c - t0 + 1;
    endfunction

    int nv0, nl0, nd0;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
        for (int i = 0; i < NV; i++) mem[24 + i] = 12'(i + 1);
        for (int i = 0; i < NV; i++) mem[40 + i] = 12'hA00 + 12'(i + 3);

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // T1: bin 3, ids 1..8, full level window 0..7
        nv0 = nv; nl0 = nl; nd0 = nd;
        do_start(10'd3, 16'd0, 16'd7, 1'b0);
        repeat (C_DONE + 1) @(posedge clk);
        #1;
        chk("t1_var_writes", nv - nv0, 8);
        chk("t1_lvl_writes", nl - nl0, 8);
        chk("t1_done_count", nd - nd0, 1);
        chk("t1_last_var_cycle", cyc_of(last_v_c), 9);
        chk("t1_done_cycle", cyc_of(done_c), 18);

        // T2: empty slot 5, level window 4..6, second start at cycle 5
        mem[29] = '0;
        nv0 = nv; nl0 = nl; nd0 = nd;
        do_start(10'd3, 16'd4, 16'd6, 1'b0);
        repeat (4) @(posedge clk);
        #1 start_store = 1'b1;
        @(posedge clk);
        #1 start_store = 1'b0;
        repeat (C_DONE - 4) @(posedge clk);
        #1;
        chk("t2_var_writes", nv - nv0, 7);
        chk("t2_lvl_writes", nl - nl0, 3);
        chk("t2_last_lvl_cycle", cyc_of(last_l_c), 12);
        chk("t2_done_count", nd - nd0, 1);
        chk("t2_done_cycle", cyc_of(done_c), 18);

        // T3: reset asserted in cycle 11 aborts the store
        nv0 = nv; nl0 = nl; nd0 = nd;
        do_start(10'd5, 16'd2, 16'd100, 1'b0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("t3_var_writes", nv - nv0, 8);
        chk("t3_lvl_writes", nl - nl0, 1);
        chk("t3_done_count", nd - nd0, 0);

        // T4: start on the first edge after reset release, top-of-range levels
        nv0 = nv; nl0 = nl; nd0 = nd;
        do_start(10'd5, 16'hFFFE, 16'hFFFF, 1'b1);
        repeat (C_DONE + 3) @(posedge clk);
        #1;
        chk("t4_var_writes", nv - nv0, 8);
        chk("t4_lvl_writes", nl - nl0, 2);
        chk("t4_done_count", nd - nd0, 1);
        chk("t4_done_cycle", cyc_of(done_c), 18);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_bin.md
STORE_BIN -- requirements
Module: store_bin

Interface
REQ-001 SHALL have parameter NUM_VARS_A_BIN, default 8, var slots per bin.
REQ-002 SHALL have parameter NUM_LVLS_A_BIN, default 8, lvl slots per bin.
REQ-003 SHALL have parameters WIDTH_VARS 12, WIDTH_LVL 16, WIDTH_BIN_ID 10, WIDTH_VAR_STATES 30, WIDTH_LVL_STATES 30, ADDR_WIDTH_VARS 9, ADDR_WIDTH_VARS_STATES 9, ADDR_WIDTH_LVLS_STATES 9.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports:
- clk  in  1  clock
- rst  in  1  async active-low reset
- start_store  in  1  one-cycle store request
- request_bin_num_i  in  WIDTH_BIN_ID  bin being written back
- base_lvl_i  in  WIDTH_LVL  lowest lvl held by the engine for this bin
- cur_lvl_i  in  WIDTH_LVL  highest valid lvl
- var_states_i  in  WIDTH_VAR_STATES*NUM_VARS_A_BIN  engine var states, slot k at bits [k*W +: W]
- lvl_states_i  in  WIDTH_LVL_STATES*NUM_LVLS_A_BIN  engine lvl states, slot j likewise
- apply_store_o  out  1  high while busy (BRAM mux select)
- done_store  out  1  one-cycle completion pulse
- ram_data_v_i  in  WIDTH_VARS  var-id RAM read data (1-cycle latency)
- ram_addr_v_o  out  ADDR_WIDTH_VARS  var-id RAM address
- ram_we_v_state_o  out  1  var-state RAM write enable
- ram_addr_v_state_o  out  ADDR_WIDTH_VARS_STATES  var-state write address
- ram_data_v_state_o  out  WIDTH_VAR_STATES  var-state write data
- ram_we_l_state_o  out  1  lvl-state RAM write enable
- ram_addr_l_state_o  out  ADDR_WIDTH_LVLS_STATES  lvl-state write address
- ram_data_l_state_o  out  WIDTH_LVL_STATES  lvl-state write data

Function
REQ-006 SHALL implement FSM IDLE, STORE_VS, STORE_LS, DONE.
REQ-007 SHALL go IDLE->STORE_VS on the edge sampling start_store=1, capturing request_bin_num_i, base_lvl_i, cur_lvl_i, var_states_i and lvl_states_i into snapshot registers.
REQ-008 SHALL ignore start_store outside IDLE; snapshot SHALL stay unchanged.
REQ-009 SHALL compute var base address = bin*NUM_VARS_A_BIN, truncated to ADDR_WIDTH_VARS.
REQ-010 SHALL run vs_cnt 0..NUM_VARS_A_BIN in STORE_VS, one cycle each (N+1 cycles); ram_addr_v_o = base+vs_cnt while vs_cnt<N, else 0.
REQ-011 SHALL, in cycle vs_cnt=k+1 (k=0..N-1), drive ram_addr_v_state_o=ram_data_v_i, ram_data_v_state_o=snapshot slot k, ram_we_v_state_o=1 unless ram_data_v_i==0 (empty slot, write suppressed).
REQ-012 SHALL go STORE_VS->STORE_LS after vs_cnt=N.
REQ-013 SHALL run ls_cnt 0..NUM_LVLS_A_BIN-1 in STORE_LS; drive ram_addr_l_state_o=base_lvl+ls_cnt (truncated), ram_data_l_state_o=snapshot slot ls_cnt, ram_we_l_state_o=1 only if base_lvl+ls_cnt<=cur_lvl (compared at WIDTH_LVL+1 bits, no wrap).
REQ-014 SHALL go STORE_LS->DONE after ls_cnt=N_L-1, DONE->IDLE unconditionally.
REQ-015 SHALL assert done_store only in the DONE cycle; with defaults it is high in cycle 18 after the start edge.
REQ-016 SHALL assert apply_store_o in STORE_VS, STORE_LS, DONE; low in IDLE.
REQ-017 SHALL hold all RAM addresses, data and write enables at 0 whenever no write is being issued.
REQ-018 SHALL never assert both write enables in the same cycle.

Reset
REQ-019 SHALL, on rst low at any time incl. mid-store, force IDLE, counters 0, snapshots 0, all outputs 0; the store is aborted and SHALL NOT resume.
REQ-020 SHALL accept start_store on the first edge after rst deasserts.

Structure
REQ-021 SHALL take width parameters and the FSM state encoding from the shared package sat_bin_pkg, shared with load_bin.
REQ-022 SHALL be a single module; no sub-module.

Verification
REQ-023 Bin 3 start, var ids 1..8 at RAM addr 24..31 -> eight var-state writes, addr 1..8, data = slots 0..7, cycles 2..9.
REQ-024 Slot 5 var id 0 -> no var-state write in cycle 7; other seven writes intact.
REQ-025 base_lvl=4, cur_lvl=6 -> lvl writes only addr 4,5,6 (slots 0..2), cycles 10..12; none in cycles 13..17.
REQ-026 start_store pulsed again at cycle 5 -> ignored, exactly one done_store at cycle 18.
REQ-027 rst low at cycle 11 -> all outputs 0 immediately, no further writes, no done_store.
REQ-028 base_lvl=0xFFFE, cur_lvl=0xFFFF -> two lvl writes only, no wrap-around writes.
